cfg_init_seq: RTL and testbench

//   Power-on and on-demand initialiser for a bank of constant-derived

---
 rtl/cfg_init_seq.sv | 144 ++++++++++++++
 tb/tb_cfg_init_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/cfg_init_seq.sv
// Power-on / on-demand initialiser for a parameter-derived register bank.
// After reset release, and again on each start request while idle, it
// writes DEPTH words to the bank over a valid/ready port. Slot k receives
// (INIT_VAL + k*STEP), evaluated at 32 bits and truncated to WIDTH.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   ST_BOOT  | reset held or just released; no write presented yet
//   ST_WRITE | presenting slot wr_addr; advances on wr_valid && wr_ready
//   ST_DONE  | all slots written; done held; waiting for start
module cfg_init_seq #(
  parameter int          WIDTH    = 1,
  parameter int          DEPTH    = 4,
  parameter int unsigned INIT_VAL = 1,
  parameter int unsigned STEP     = 0,
  localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             wr_valid,
  input  logic             wr_ready,
  output logic [AW-1:0]    wr_addr,
  output logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] INIT_W    = WIDTH'(INIT_VAL);
  localparam logic [AW-1:0]    LAST_ADDR = AW'(DEPTH - 1);

  state_t           r_state;
  logic             r_valid;
  logic [AW-1:0]    r_addr;
  logic [WIDTH-1:0] r_data;
  logic             r_busy;
  logic             r_done;

  state_t           w_state_nxt;
  logic             w_valid_nxt;
  logic [AW-1:0]    w_addr_nxt;
  logic [WIDTH-1:0] w_data_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;

  logic [AW-1:0]    w_addr_inc;
  logic [WIDTH-1:0] w_data_inc;

  // Next slot index and its value; the slot value is evaluated directly from
  // the index so the 32-bit wrap behaviour holds for any WIDTH.
  always_comb begin
    w_addr_inc = r_addr + AW'(1);
    w_data_inc = WIDTH'(INIT_VAL + (32'(w_addr_inc) * STEP));
  end

  // Next-state and registered-output decode.
  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_valid;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_busy_nxt  = r_busy;
    w_done_nxt  = r_done;

    case (r_state)
      ST_BOOT: begin
        w_state_nxt = ST_WRITE;
        w_valid_nxt = 1'b1;
        w_busy_nxt  = 1'b1;
        w_done_nxt  = 1'b0;
        w_addr_nxt  = '0;
        w_data_nxt  = INIT_W;
      end

      ST_WRITE: begin
        if (wr_ready) begin
          if (r_addr == LAST_ADDR) begin
            w_state_nxt = ST_DONE;
            w_valid_nxt = 1'b0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_addr_nxt  = '0;
            w_data_nxt  = INIT_W;
          end else begin
            w_addr_nxt = w_addr_inc;
            w_data_nxt = w_data_inc;
          end
        end
      end

      ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_WRITE;
          w_valid_nxt = 1'b1;
          w_busy_nxt  = 1'b1;
          w_done_nxt  = 1'b0;
          w_addr_nxt  = '0;
          w_data_nxt  = INIT_W;
        end
      end

      default: begin
        w_state_nxt = ST_BOOT;
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_addr_nxt  = '0;
        w_data_nxt  = INIT_W;
      end
    endcase
  end

  // State and output registers; reset forces the idle, nothing-written view.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_BOOT;
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= INIT_W;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_valid_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign wr_valid = r_valid;
  assign wr_addr  = r_addr;
  assign wr_data  = r_data;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_cfg_init_seq.sv
// Bench for cfg_init_seq: four configurations run side by side against a
// slot-index reference model (idle / writing slot k / finished).
module tb_cfg_init_seq;

  localparam int N = 4;
  localparam int unsigned PW[N] = '{8, 1, 4, 1};
  localparam int unsigned PD[N] = '{4, 4, 4, 1};
  localparam int unsigned PI[N] = '{1, 1, 15, 1};
  localparam int unsigned PS[N] = '{2, 1, 1, 0};

  localparam int M_BOOT = 0;
  localparam int M_WR   = 1;
  localparam int M_DONE = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] rdy = '1;

  logic         a_valid, a_busy, a_done;
  logic [1:0]   a_addr;
  logic [7:0]   a_data;
  logic         b_valid, b_busy, b_done;
  logic [1:0]   b_addr;
  logic [0:0]   b_data;
  logic         c_valid, c_busy, c_done;
  logic [1:0]   c_addr;
  logic [3:0]   c_data;
  logic         d_valid, d_busy, d_done;
  logic [0:0]   d_addr;
  logic [0:0]   d_data;

  logic         o_valid[N];
  logic         o_busy[N];
  logic         o_done[N];
  logic [31:0]  o_addr[N];
  logic [31:0]  o_data[N];

  int           n_cmp = 0;
  int           n_err = 0;
  int           m_state[N];
  int unsigned  m_k[N];
  int unsigned  obs_cnt[N];

  always #5 clk = ~clk;

  cfg_init_seq #(.WIDTH(8), .DEPTH(4), .INIT_VAL(1), .STEP(2)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .wr_valid(a_valid), .wr_ready(rdy[0]),
    .wr_addr(a_addr), .wr_data(a_data), .busy(a_busy), .done(a_done));
  cfg_init_seq #(.WIDTH(1), .DEPTH(4), .INIT_VAL(1), .STEP(1)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start), .wr_valid(b_valid), .wr_ready(rdy[1]),
    .wr_addr(b_addr), .wr_data(b_data), .busy(b_busy), .done(b_done));
  cfg_init_seq #(.WIDTH(4), .DEPTH(4), .INIT_VAL(15), .STEP(1)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start), .wr_valid(c_valid), .wr_ready(rdy[2]),
    .wr_addr(c_addr), .wr_data(c_data), .busy(c_busy), .done(c_done));
  cfg_init_seq #(.WIDTH(1), .DEPTH(1), .INIT_VAL(1), .STEP(0)) u_d (
    .clk(clk), .rst_n(rst_n), .start(start), .wr_valid(d_valid), .wr_ready(rdy[3]),
    .wr_addr(d_addr), .wr_data(d_data), .busy(d_busy), .done(d_done));

  assign o_valid[0] = a_valid;  assign o_busy[0] = a_busy;  assign o_done[0] = a_done;
  assign o_valid[1] = b_valid;  assign o_busy[1] = b_busy;  assign o_done[1] = b_done;
  assign o_valid[2] = c_valid;  assign o_busy[2] = c_busy;  assign o_done[2] = c_done;
  assign o_valid[3] = d_valid;  assign o_busy[3] = d_busy;  assign o_done[3] = d_done;
  assign o_addr[0] = {30'b0, a_addr};  assign o_data[0] = {24'b0, a_data};
  assign o_addr[1] = {30'b0, b_addr};  assign o_data[1] = {31'b0, b_data};
  assign o_addr[2] = {30'b0, c_addr};  assign o_data[2] = {28'b0, c_data};
  assign o_addr[3] = {31'b0, d_addr};  assign o_data[3] = {31'b0, d_data};

  // Slot value: INIT + k*STEP in 32-bit arithmetic, reduced modulo 2^WIDTH.
  function automatic logic [31:0] exp_data(int i, int unsigned k);
    logic [31:0] s;
    s = PI[i] + k * PS[i];
    if (PW[i] < 32) s = s % (32'd1 << PW[i]);
    return s;
  endfunction

  task automatic chk(string tag, int i, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s[dut%0d] observed=%0h expected=%0h t=%0t", tag, i, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_state[i] = M_BOOT;
      m_k[i]     = 0;
      obs_cnt[i] = 0;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      chk("wr_valid", i, 32'(o_valid[i]), 32'(m_state[i] == M_WR));
      chk("busy",     i, 32'(o_busy[i]),  32'(m_state[i] == M_WR));
      chk("done",     i, 32'(o_done[i]),  32'(m_state[i] == M_DONE));
      chk("wr_addr",  i, o_addr[i], (m_state[i] == M_WR) ? m_k[i] : 32'd0);
      if (m_state[i] != M_DONE)
        chk("wr_data", i, o_data[i], exp_data(i, m_k[i]));
      chk("busy_and_done", i, 32'(o_busy[i] && o_done[i]), 32'd0);
    end
  endtask

  // One clock: count accepted writes, advance the model on the edge, check at negedge.
  task automatic tick();
    for (int i = 0; i < N; i++)
      if (rst_n && o_valid[i] && rdy[i]) obs_cnt[i]++;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int i = 0; i < N; i++) begin
        case (m_state[i])
          M_BOOT: begin
            m_state[i] = M_WR;
            m_k[i]     = 0;
          end
          M_WR: begin
            if (rdy[i]) begin
              if (m_k[i] == PD[i] - 1) begin
                m_state[i] = M_DONE;
                chk("write_count", i, obs_cnt[i], PD[i]);
                obs_cnt[i] = 0;
              end else begin
                m_k[i]++;
              end
            end
          end
          default: begin
            if (start) begin
              m_state[i] = M_WR;
              m_k[i]     = 0;
              obs_cnt[i] = 0;
            end
          end
        endcase
      end
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic async_reset_midcycle();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    start = 1'b0;
    rdy   = '1;
    @(negedge clk);
    check_all();
    tick();
    tick();
    // Release: first write one cycle later, done DEPTH+1 cycles after release.
    rst_n = 1'b1;
    check_all();
    repeat (6) tick();

    // Restart, then stall instance A for 3 cycles while it presents slot 1.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("stall_addr", 0, o_addr[0], 32'd1);
    rdy[0] = 1'b0;
    repeat (3) tick();
    chk("stall_hold_data", 0, o_data[0], 32'd3);
    rdy[0] = 1'b1;
    repeat (6) tick();

    // Start pulse in DONE restarts; a pulse mid-write is ignored.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();

    // Asynchronous reset between edges while instance A presents slot 2.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("pre_reset_addr", 0, o_addr[0], 32'd2);
    async_reset_midcycle();
    repeat (7) tick();

    // Randomised ready stalls, start pulses and occasional mid-cycle resets.
    for (int n = 0; n < 400; n++) begin
      rdy   = 4'($urandom);
      start = ($urandom_range(3) == 0);
      if ($urandom_range(49) == 0) async_reset_midcycle();
      tick();
    end
    rdy   = '1;
    start = 1'b0;
    repeat (6) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
